// File: rtl/prog_mem_loader_if.sv
// Bus between prog_mem_loader and its users: CPU fetch port plus the loader handshake.
// CHECKSUM is present only when PROG_MEM_LOADER_CHECKSUM_EN is defined.
interface prog_mem_loader_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
);
    logic [ADDR_W-1:0] ADDRESS;
    logic [DATA_W-1:0] OUT;
    logic              LOAD_START;
    logic              LOAD_VALID;
    logic [DATA_W-1:0] LOAD_DATA;
    logic              LOAD_READY;
    logic              BUSY;
    logic              LOAD_DONE;
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] CHECKSUM;

    modport slave (
        input  ADDRESS, LOAD_START, LOAD_VALID, LOAD_DATA,
        output OUT, LOAD_READY, BUSY, LOAD_DONE, CHECKSUM
    );
    modport master (
        output ADDRESS, LOAD_START, LOAD_VALID, LOAD_DATA,
        input  OUT, LOAD_READY, BUSY, LOAD_DONE, CHECKSUM
    );
`else
    modport slave (
        input  ADDRESS, LOAD_START, LOAD_VALID, LOAD_DATA,
        output OUT, LOAD_READY, BUSY, LOAD_DONE
    );
    modport master (
        output ADDRESS, LOAD_START, LOAD_VALID, LOAD_DATA,
        input  OUT, LOAD_READY, BUSY, LOAD_DONE
    );
`endif
endinterface

// File: rtl/prog_mem_loader.sv
// Program memory with combinational fetch and a run-time full-image load port.
// Optional running checksum of loaded words: define PROG_MEM_LOADER_CHECKSUM_EN.
module prog_mem_loader #(
    parameter int unsigned       ADDR_W = 4,
    parameter int unsigned       DATA_W = 8,
    parameter logic [DATA_W-1:0] FILL   = '0
) (
    input  logic              CLK,
    input  logic              RESET,
    prog_mem_loader_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_W;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] wp_q, wp_d;
    logic              busy_q, busy_d;
    logic              ready_q, ready_d;
    logic              done_q, done_d;
    logic              accept_c;
    logic              start_c;

    // Power-up image is all zeros; RESET deliberately leaves the array alone.
    logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

    always_comb begin
        state_d  = state_q;
        wp_d     = wp_q;
        accept_c = 1'b0;
        start_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.LOAD_START) begin
                    state_d = LOAD;
                    wp_d    = '0;
                    start_c = 1'b1;
                end
            end
            LOAD: begin
                accept_c = bus.LOAD_VALID && ready_q;
                if (accept_c) begin
                    wp_d = wp_q + ADDR_W'(1);
                    if (wp_q == ADDR_W'(DEPTH - 1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d  = (state_d != IDLE);
        ready_d = (state_d == LOAD);
        done_d  = (state_d == DONE);
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            wp_q    <= '0;
            busy_q  <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wp_q    <= wp_d;
            busy_q  <= busy_d;
            ready_q <= ready_d;
            done_q  <= done_d;
        end
    end

    // A word presented while RESET is high must not land in the array.
    always_ff @(posedge CLK) begin
        if (!RESET && accept_c) begin
            mem_q[wp_q] <= bus.LOAD_DATA;
        end
    end

    assign bus.OUT        = busy_q ? FILL : mem_q[bus.ADDRESS];
    assign bus.LOAD_READY = ready_q;
    assign bus.BUSY       = busy_q;
    assign bus.LOAD_DONE  = done_q;

`ifdef PROG_MEM_LOADER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (start_c) begin
            csum_d = '0;
        end else if (accept_c) begin
            csum_d = csum_q + bus.LOAD_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign bus.CHECKSUM = csum_q;
`else
    logic unused_start;
    assign unused_start = start_c;
`endif
endmodule

// File: tb/tb_prog_mem_loader.sv
// Directed scoreboard bench for prog_mem_loader: reset state, loads with and without
// gaps, ignored restarts, reset mid-load and (when enabled) the checksum.
module tb_prog_mem_loader;
    localparam int unsigned ADDR_W = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned DEPTH  = 16;
    localparam logic [7:0]  FILL   = 8'h00;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    logic [7:0] model [DEPTH];
    logic [7:0] img   [DEPTH];
    logic [7:0] csum_m;
    logic [7:0] exp_q [$];

    prog_mem_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    prog_mem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .FILL(FILL)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Sweep every address in IDLE against the model through the scoreboard queue.
    task automatic readback(input string tag);
        for (int a = 0; a < int'(DEPTH); a++) exp_q.push_back(model[a]);
        for (int a = 0; a < int'(DEPTH); a++) begin
            bus.ADDRESS = 4'(a);
            #1;
            chk(tag, 32'(bus.OUT), 32'(exp_q.pop_front()));
        end
    endtask

    // Full load of img; mode 1 inserts gaps (valid pattern 1,0,0,...);
    // pulse_extra re-asserts LOAD_START mid-load and in the DONE cycle.
    task automatic do_load(input int mode, input bit pulse_extra);
        int  k;
        int  cyc;
        bit  v;
        k   = 0;
        cyc = 0;
        bus.LOAD_START = 1'b1;
        bus.LOAD_VALID = 1'b1;
        bus.LOAD_DATA  = 8'hEE;
        #1;
        chk("idle_ready", 32'(bus.LOAD_READY), 32'(0));
        step();
        bus.LOAD_START = 1'b0;
        csum_m = 8'h00;
        while (k < int'(DEPTH) && cyc < 200) begin
            v = (mode == 0) || (cyc % 3 == 0);
            bus.LOAD_VALID = v;
            bus.LOAD_DATA  = v ? img[k] : 8'h5A;
            bus.LOAD_START = pulse_extra && (cyc == 3);
            bus.ADDRESS    = 4'($urandom_range(0, 15));
            if (v) exp_q.push_back(img[k]);
            #1;
            if (cyc < 2 || (k == int'(DEPTH) - 1)) begin
                chk("load_ready", 32'(bus.LOAD_READY), 32'(1));
                chk("load_busy", 32'(bus.BUSY), 32'(1));
                chk("load_out_fill", 32'(bus.OUT), 32'(FILL));
                chk("load_no_done", 32'(bus.LOAD_DONE), 32'(0));
            end
            step();
            if (v) begin
                model[k] = exp_q.pop_front();
                csum_m   = csum_m + model[k];
                k++;
            end
            cyc++;
        end
        if (k < int'(DEPTH)) chk("load_timeout", 32'(k), 32'(DEPTH));
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_START = pulse_extra;
        #1;
        chk("done_pulse", 32'(bus.LOAD_DONE), 32'(1));
        chk("done_busy", 32'(bus.BUSY), 32'(1));
        chk("done_ready", 32'(bus.LOAD_READY), 32'(0));
        step();
        bus.LOAD_START = 1'b0;
        chk("after_done", 32'(bus.LOAD_DONE), 32'(0));
        chk("after_busy", 32'(bus.BUSY), 32'(0));
        step();
        chk("idle_stays", 32'(bus.BUSY), 32'(0));
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("checksum", 32'(bus.CHECKSUM), 32'(csum_m));
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        for (int a = 0; a < int'(DEPTH); a++) model[a] = 8'h00;
        rst = 1'b1;
        bus.ADDRESS    = '0;
        bus.LOAD_START = 1'b0;
        bus.LOAD_VALID = 1'b0;
        bus.LOAD_DATA  = '0;
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", 32'(bus.BUSY), 32'(0));
        chk("rst_ready", 32'(bus.LOAD_READY), 32'(0));
        chk("rst_done", 32'(bus.LOAD_DONE), 32'(0));
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("rst_csum", 32'(bus.CHECKSUM), 32'(0));
`endif
        readback("rd_init");

        // Back-to-back load B7,01..0E,FF
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'(k);
        img[0]  = 8'hB7;
        img[15] = 8'hFF;
        step();
        do_load(0, 1'b0);
        bus.ADDRESS = 4'd0;
        #1 chk("rd_addr0", 32'(bus.OUT), 32'(8'hB7));
        bus.ADDRESS = 4'd15;
        #1 chk("rd_addr15", 32'(bus.OUT), 32'(8'hFF));
        readback("rd_b2b");

        // Load with gaps
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'(8'h40 + 8'(k * 3));
        step();
        do_load(1, 1'b0);
        readback("rd_gaps");

        // LOAD_START re-pulsed mid-load and during DONE
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'(8'hC0 ^ 8'(k));
        step();
        do_load(0, 1'b1);
        readback("rd_restart");

        // Reset after 5 words of AA over an all-11 image
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'h11;
        step();
        do_load(0, 1'b0);
        bus.LOAD_START = 1'b1;
        step();
        bus.LOAD_START = 1'b0;
        for (int k = 0; k < 5; k++) begin
            bus.LOAD_VALID = 1'b1;
            bus.LOAD_DATA  = 8'hAA;
            step();
            model[k] = 8'hAA;
        end
        bus.LOAD_DATA = 8'hAA;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.LOAD_VALID = 1'b0;
        chk("midrst_busy", 32'(bus.BUSY), 32'(0));
        chk("midrst_ready", 32'(bus.LOAD_READY), 32'(0));
        chk("midrst_done", 32'(bus.LOAD_DONE), 32'(0));
        step();
        chk("midrst_no_done", 32'(bus.LOAD_DONE), 32'(0));
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("midrst_csum", 32'(bus.CHECKSUM), 32'(0));
`endif
        readback("rd_midrst");

        // Pointer restarts at 0 after the reset
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'h20;
        do_load(0, 1'b0);
        readback("rd_20");
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("csum_20", 32'(bus.CHECKSUM), 32'(8'h00));
`endif
        for (int k = 0; k < int'(DEPTH); k++) img[k] = 8'(k);
        do_load(1, 1'b0);
        readback("rd_ramp");
`ifdef PROG_MEM_LOADER_CHECKSUM_EN
        chk("csum_ramp", 32'(bus.CHECKSUM), 32'(8'h78));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
